// File: rtl/led_counter_pkg.sv
// Shared constants and helpers for the prescaled LED counter.
// Saturating mode is selected by COUNTER_SATURATE_EN.
package led_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Prescaler width: clog2 with a floor of one bit
  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_counter_gen_tick_gen.sv
// Prescaler: one tick per DIV enabled clocks.
// clr restarts the period; en freezes it without restart.
module tick_gen
  import led_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = pre_width(DIV);
  localparam logic [PW-1:0] LASTP = PW'(DIV - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == LASTP) ? '0 : pre + 1'b1;
    end
  end

  assign tick = en && (pre == LASTP);

endmodule

// File: rtl/led_counter_gen.sv
// Prescaled up/down modulo counter driving an LED bank.
// Define COUNTER_SATURATE_EN to clamp at the limits instead of wrapping.
module led_counter_gen
  import led_counter_pkg::*;
#(
  parameter int     WIDTH = 8,
  parameter longint MOD   = longint'(1) << WIDTH,
  parameter int     DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             tc
);

  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MOD - 1);

`ifdef COUNTER_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic           tick;
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] nxt;
  logic [WIDTH:0] ld_x;
  logic           at_lim;
  logic           unused_msb;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // One spare bit so MOD-1 compares never rely on overflow
  always_comb begin
    cnt_x  = {1'b0, leds};
    nxt    = cnt_x;
    at_lim = 1'b0;
    if (up == DIR_UP) begin
      if (cnt_x == LAST) begin
        at_lim = 1'b1;
        nxt    = SAT ? LAST : '0;
      end else begin
        nxt = cnt_x + 1'b1;
      end
    end else begin
      if (cnt_x == '0) begin
        at_lim = 1'b1;
        nxt    = SAT ? '0 : LAST;
      end else begin
        nxt = cnt_x - 1'b1;
      end
    end
    ld_x = {1'b0, load_val};
    if (ld_x > LAST) begin
      ld_x = LAST;
    end
  end

  assign unused_msb = nxt[WIDTH] ^ ld_x[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds <= '0;
      tc   <= 1'b0;
    end else if (load) begin
      leds <= ld_x[WIDTH-1:0];
      tc   <= 1'b0;
    end else if (tick) begin
      leds <= nxt[WIDTH-1:0];
      tc   <= at_lim;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_counter_gen.sv
// Bench for led_counter_gen: DIV=1 and DIV=4 instances, MOD=10,
// checked each cycle against a behavioural model plus literal points.
module tb_led_counter_gen;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] leds1, leds4;
  logic       tc1, tc4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  led_counter_gen #(.WIDTH(4), .MOD(10), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .leds(leds1), .tc(tc1)
  );

  led_counter_gen #(.WIDTH(4), .MOD(10), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .leds(leds4), .tc(tc4)
  );

  // Model: count of enabled cycles since last step, value in 0..9
  int m_cnt[2];
  int m_pre[2];
  bit m_tc[2];
  int divs[2] = '{1, 4};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int c, p;
      bit t;
      c = m_cnt[i];
      p = m_pre[i];
      t = 1'b0;
      if (rst) begin
        c = 0;
        p = 0;
      end else if (load) begin
        c = (int'(load_val) > 9) ? 9 : int'(load_val);
        p = 0;
      end else if (en) begin
        p = p + 1;
        if (p == divs[i]) begin
          p = 0;
          if (up) begin
            if (c == 9) begin
              t = 1'b1;
              c = SAT ? 9 : 0;
            end else c = c + 1;
          end else begin
            if (c == 0) begin
              t = 1'b1;
              c = SAT ? 0 : 9;
            end else c = c - 1;
          end
        end
      end
      m_cnt[i] <= c;
      m_pre[i] <= p;
      m_tc[i]  <= t;
    end
  end

  always @(negedge clk) begin
    n_chk = n_chk + 4;
    if (int'(leds1) != m_cnt[0]) begin
      n_fail++;
      $display("FAIL model_leds1 t=%0t got %0d want %0d", $time, leds1, m_cnt[0]);
    end
    if (tc1 != m_tc[0]) begin
      n_fail++;
      $display("FAIL model_tc1 t=%0t got %0b want %0b", $time, tc1, m_tc[0]);
    end
    if (int'(leds4) != m_cnt[1]) begin
      n_fail++;
      $display("FAIL model_leds4 t=%0t got %0d want %0d", $time, leds4, m_cnt[1]);
    end
    if (tc4 != m_tc[1]) begin
      n_fail++;
      $display("FAIL model_tc4 t=%0t got %0b want %0b", $time, tc4, m_tc[1]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit e, input bit u, input bit l, input int v);
    @(negedge clk);
    en = e;
    up = u;
    load = l;
    load_val = 4'(v);
  endtask

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds1", int'(leds1), 0);
    chk("rst_tc1", int'(tc1), 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    up = 1'b1;
    step_n(9);
    chk("up_leds1_9", int'(leds1), 9);
    chk("up_leds4_2", int'(leds4), 2);
    step_n(1);
    chk("wrap_leds1", int'(leds1), 0);
    chk("wrap_tc1", int'(tc1), 1);
    step_n(1);
    chk("post_wrap_leds1", int'(leds1), 1);
    chk("post_wrap_tc1", int'(tc1), 0);
    step_n(1);
    chk("div4_leds4_3", int'(leds4), 3);

    drive(1, 1, 1, 12);
    step_n(1);
    chk("load_clamp1", int'(leds1), 9);
    chk("load_clamp4", int'(leds4), 9);
    drive(1, 1, 0, 0);
    step_n(3);
    chk("load_hold4", int'(leds4), 9);
    step_n(1);
    chk("load_wrap4", int'(leds4), 0);
    chk("load_wrap_tc4", int'(tc4), 1);

    drive(1, 1, 1, 3);
    step_n(1);
    drive(1, 1, 0, 0);
    step_n(2);
    drive(0, 1, 0, 0);
    step_n(3);
    drive(1, 1, 0, 0);
    step_n(1);
    chk("en_gap_hold4", int'(leds4), 3);
    step_n(1);
    chk("en_gap_step4", int'(leds4), 4);

    drive(1, 1, 1, 5);
    step_n(1);
    drive(1, 1, 0, 0);
    step_n(3);
    drive(1, 1, 1, 7);
    step_n(1);
    chk("load_beats_tick4", int'(leds4), 7);
    chk("load_beats_tc4", int'(tc4), 0);
    drive(1, 1, 0, 0);
    step_n(3);
    chk("load_pre_clr4", int'(leds4), 7);
    step_n(1);
    chk("load_pre_step4", int'(leds4), 8);

    drive(1, 0, 1, 0);
    step_n(1);
    drive(1, 0, 0, 0);
    step_n(1);
    chk("down_lim_leds1", int'(leds1), SAT ? 0 : 9);
    chk("down_lim_tc1", int'(tc1), 1);
    step_n(1);
    chk("down_next_leds1", int'(leds1), SAT ? 0 : 8);
    chk("down_next_tc1", int'(tc1), SAT ? 1 : 0);

    drive(1, 1, 1, 9);
    step_n(1);
    drive(1, 1, 0, 0);
    step_n(1);
    chk("up_lim_leds1", int'(leds1), SAT ? 9 : 0);
    chk("up_lim_tc1", int'(tc1), 1);
    drive(1, 0, 0, 0);
    step_n(1);
    chk("rev_leds1", int'(leds1), SAT ? 8 : 9);
    chk("rev_tc1", int'(tc1), SAT ? 0 : 1);

    drive(1, 1, 0, 0);
    step_n(3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_leds1", int'(leds1), 0);
    chk("async_rst_tc1", int'(tc1), 0);
    chk("async_rst_leds4", int'(leds4), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 120; k++) begin
      drive($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 15));
    end
    drive(0, 1, 0, 0);
    step_n(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_counter_gen.md
# led_counter_gen

Parametrised, prescaled up/down modulo counter that drives a board LED bank. It is the general-purpose successor to the plain free-running LED counter: configurable width, modulus and tick rate, with direction control, synchronous load and a terminal-count pulse. It sits between the board clock and the LED pins, or feeds other blocks needing a slow event counter.

## Interface
- WIDTH, 8: counter and LED width in bits (1..32).
- MOD, 2**WIDTH: count modulus; count range 0..MOD-1 (2..2**WIDTH).
- DIV, 1: prescaler ratio; one count step per DIV enabled clocks (1..2**24).
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; gates both prescaler and counter.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- leds  output  WIDTH  current count, registered.
- tc  output  1  registered terminal-count pulse, one cycle wide.

## Operation
- Prescaler pre: width max(1,$clog2(DIV)), counts 0..DIV-1 while en=1, wraps to 0. Holds when en=0. Internal tick = en && (pre == DIV-1); with DIV=1, tick = en.
- Priority per edge: rst > load > tick > hold.
- load=1: leds <= load_val, or MOD-1 if load_val >= MOD; pre <= 0; tc <= 0. Load ignores en.
- tick, up=1: leds <= leds+1; if leds == MOD-1, leds <= 0 and tc <= 1.
- tick, up=0: leds <= leds-1; if leds == 0, leds <= MOD-1 and tc <= 1.
- All other cycles: leds holds, tc <= 0.
- Arithmetic done in WIDTH+1 bits; wrap compares against MOD-1 explicitly, never relying on natural WIDTH overflow (MOD may be non-power-of-two).
- up sampled only on tick cycles; changing up between ticks has no effect until the next tick.
- en deasserted mid-prescale: pre frozen, resumes on re-enable (no restart).

## Timing
- Reset values: leds = 0, tc = 0, pre = 0; asynchronous assertion, deassertion sampled at next clk edge.
- Latency: tick in cycle n -> leds and tc valid after edge n (one cycle). Load in cycle n -> leds = load_val after edge n.
- With en held high: leds steps every DIV cycles; first step occurs DIV cycles after reset release or load.
- tc high exactly one cycle per wrap, coincident with the wrapped leds value.
- rst asserted mid-operation: immediate clear regardless of load/tick.

## Configuration
- COUNTER_SATURATE_EN defined: no wrap. Up-tick at MOD-1 holds MOD-1; down-tick at 0 holds 0; tc pulses one cycle on every tick attempted at the limit.
- Undefined (default): modulo wrap as in Operation.

## Structure
- Shared package led_counter_pkg: direction constants DIR_UP=1'b1, DIR_DOWN=1'b0; helper function for prescaler width (clog2 with minimum 1).
- One sub-module: tick_gen (parameter DIV; ports clk, rst, en, clr, tick), holding the prescaler; load drives clr.
- Top holds count register, wrap/saturate logic, tc register.

## Test plan
- Reset: rst=1 mid-count with leds=0x5A -> leds=0, tc=0 without waiting for clk edge.
- Wrap up: WIDTH=4, MOD=10, DIV=1, en=1, up=1 from 0 -> leds 0..9, then 0 with tc=1 for one cycle, every 10 cycles.
- Wrap down: MOD=10, load_val=0 then up=0 -> next tick leds=9, tc=1; following tick leds=8, tc=0.
- Prescale: DIV=4, en=1 -> leds increments every 4th edge; drop en for 3 cycles mid-period -> step delayed by exactly 3 cycles.
- Load: load_val=12 with MOD=10 -> leds=9; load asserted same cycle as tick -> load wins, pre cleared, next step 4 cycles later (DIV=4).
- Saturate (COUNTER_SATURATE_EN): MOD=10, at leds=9 up-tick -> leds stays 9, tc=1 each tick; up=0 -> leds 8.
